// File: rtl/serial_pkg.sv
// Shared constants and state encoding for the UART receive/transmit pair.
package serial_pkg;

    localparam int DEFAULT_CLOCKS_PER_BIT = 52;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/serial_rx_fifo.sv
// Circular receive FIFO. A push into a full FIFO is taken only when a pop frees a slot in the same cycle.
module serial_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      count;
    logic             do_push, do_pop;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // When full, wr_ptr == rd_ptr: the slot being overwritten is the one popped this cycle.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/serial_receiver.sv
// 8N1 UART receiver: synchronizer, framing FSM, receive FIFO and sticky error flags.
module serial_receiver
    import serial_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       framing_error,
    output logic       overrun_error,
    input  logic       clear_errors
);
    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLOCKS_PER_BIT / 2 - 1);

    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_meta, rx_s;
    logic          stop_sample, push_req, framing_set, overrun_set;
    logic          pop, fifo_full, fifo_empty;

    // Both flops reset high so a reset never looks like a start edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= serial_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == CNT_MID) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7) state <= STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : WAIT_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stop_sample = (state == STOP) && (cnt == CNT_LAST);
    assign push_req    = stop_sample && rx_s;
    assign framing_set = stop_sample && !rx_s;
    assign pop         = rx_valid && rx_ready;
    assign overrun_set = push_req && fifo_full && !pop;
    assign rx_valid    = !fifo_empty;
    assign rx_busy     = (state != IDLE);

    serial_rx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_req),
        .pop       (pop),
        .push_data (shreg),
        .pop_data  (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A new error event beats a simultaneous clear.
    always_ff @(posedge clock) begin
        if (!reset) begin
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if (framing_set)       framing_error <= 1'b1;
            else if (clear_errors) framing_error <= 1'b0;
            if (overrun_set)       overrun_error <= 1'b1;
            else if (clear_errors) overrun_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver with a pop-side scoreboard monitor.
module tb_serial_receiver;
    localparam int CPB = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       serial_rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic       clear_errors = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, framing_error, overrun_error;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_pops  = 0;
    logic [7:0] sb [$];
    logic [7:0] mon_exp;

    serial_receiver #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .serial_rx     (serial_rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_busy       (rx_busy),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .clear_errors  (clear_errors)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Start bit plus eight data bits, LSB first; leaves the line on the last data bit.
    task automatic send_bits(input logic [7:0] b);
        serial_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            serial_rx = b[i];
            tick(CPB);
        end
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bits(b);
        serial_rx = 1'b1;
        tick(CPB + 2);
    endtask

    task automatic drain(input int exp_n, input string name);
        int start;
        start    = n_pops;
        rx_ready = 1'b1;
        for (int i = 0; i < 40 && rx_valid; i++) tick(1);
        rx_ready = 1'b0;
        check({name, "_pop_count"}, n_pops - start, exp_n);
        check({name, "_valid_after"}, {31'd0, rx_valid}, 0);
        check({name, "_data_after"}, {24'd0, rx_data}, 0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_valid"}, {31'd0, rx_valid}, 0);
        check({name, "_data"}, {24'd0, rx_data}, 0);
        check({name, "_busy"}, {31'd0, rx_busy}, 0);
        check({name, "_ferr"}, {31'd0, framing_error}, 0);
        check({name, "_oerr"}, {31'd0, overrun_error}, 0);
    endtask

    // Scoreboard monitor: every handshake pops one expected byte.
    always @(negedge clock) begin
        if (reset && rx_valid && rx_ready) begin
            n_pops++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_unexpected: got %02h, expected no data", rx_data);
            end else begin
                mon_exp = sb.pop_front();
                check("pop_data", {24'd0, rx_data}, {24'd0, mon_exp});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        tick(3);
        check_reset_values("reset");
        reset = 1'b1;
        tick(2);

        // Good frame: valid rises exactly one cycle after the stop sample.
        send_bits(8'hA5);
        serial_rx = 1'b1;
        tick(6);
        check("a5_valid_before_stop", {31'd0, rx_valid}, 0);
        tick(1);
        check("a5_valid", {31'd0, rx_valid}, 1);
        check("a5_data", {24'd0, rx_data}, 32'hA5);
        sb.push_back(8'hA5);
        tick(3);
        drain(1, "a5");

        // Short glitch: START entered then abandoned.
        serial_rx = 1'b0;
        tick(2);
        serial_rx = 1'b1;
        tick(2);
        check("glitch_busy", {31'd0, rx_busy}, 1);
        tick(20);
        check_reset_values("glitch_after");

        // Framing error with the line held low afterwards.
        send_bits(8'h3C);
        serial_rx = 1'b0;
        tick(CPB + 20);
        check("frm_ferr", {31'd0, framing_error}, 1);
        check("frm_valid", {31'd0, rx_valid}, 0);
        check("frm_busy_wait_idle", {31'd0, rx_busy}, 1);
        serial_rx = 1'b1;
        tick(4);
        check("frm_busy_released", {31'd0, rx_busy}, 0);
        check("frm_ferr_sticky", {31'd0, framing_error}, 1);
        clear_errors = 1'b1;
        tick(1);
        clear_errors = 1'b0;
        check("frm_ferr_cleared", {31'd0, framing_error}, 0);
        check("frm_fifo_empty", {31'd0, rx_valid}, 0);

        // Overrun: fifth byte dropped.
        for (int b = 1; b <= 5; b++) begin
            send_frame(8'(b));
            if (b <= 4) sb.push_back(8'(b));
        end
        check("ovr_oerr", {31'd0, overrun_error}, 1);
        check("ovr_head", {24'd0, rx_data}, 32'h01);
        drain(4, "ovr");
        clear_errors = 1'b1;
        tick(1);
        clear_errors = 1'b0;
        check("ovr_oerr_cleared", {31'd0, overrun_error}, 0);

        // Full FIFO with a pop on the exact push cycle.
        for (int b = 8'h11; b <= 8'h14; b++) begin
            send_frame(8'(b));
            sb.push_back(8'(b));
        end
        sb.push_back(8'h55);
        send_bits(8'h55);
        serial_rx = 1'b1;
        tick(6);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("fullpop_oerr", {31'd0, overrun_error}, 0);
        check("fullpop_head", {24'd0, rx_data}, 32'h12);
        tick(3);
        drain(4, "fullpop");

        // Reset in the middle of a frame, with a byte already queued.
        send_frame(8'h77);
        check("prereset_valid", {31'd0, rx_valid}, 1);
        serial_rx = 1'b0;
        tick(CPB);
        serial_rx = 1'b1;
        tick(CPB * 3);
        check("prereset_busy", {31'd0, rx_busy}, 1);
        reset = 1'b0;
        tick(2);
        check_reset_values("midreset");
        reset = 1'b1;
        tick(CPB * 6);
        check("postreset_busy", {31'd0, rx_busy}, 0);
        sb.push_back(8'h12);
        send_frame(8'h12);
        drain(1, "postreset");

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_receiver.md
# serial_receiver

Receives 8N1 asynchronous serial frames on the board's UART RX pin and presents them to the core's memory-mapped IO logic. Bytes go into a small receive FIFO, and the core pops them with a valid/ready handshake. This is the receive counterpart of `serial_transmitter` and runs on the same clock and baud divisor. Framing and overrun conditions are reported as sticky flags.

## Interface
- `CLOCKS_PER_BIT`, default 52: clock cycles per bit period (6 MHz / 115200 baud); minimum 4.
- `FIFO_DEPTH`, default 4: receive FIFO entries; power of two, ≥2.

- `clock`  in  1  single clock for all logic (same as `serial_clock`).
- `reset`  in  1  synchronous, active-low; the block resets when `reset` is sampled 0 at a `clock` edge.
- `serial_rx`  in  1  asynchronous line input; idle high.
- `rx_data`  out  8  byte at the FIFO head; 8'h00 when `rx_valid`=0.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer pop; a pop occurs on a cycle with `rx_valid` && `rx_ready`.
- `rx_busy`  out  1  frame in progress (state ≠ IDLE).
- `framing_error`  out  1  sticky: a stop bit was sampled low.
- `overrun_error`  out  1  sticky: a valid byte was dropped because the FIFO was full.
- `clear_errors`  in  1  one-cycle pulse that clears both sticky flags.

## Operation
- `serial_rx` passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized bit `rx_s`.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. One bit counter `cnt` runs 0..CLOCKS_PER_BIT-1. A 3-bit index selects the data bit.
- IDLE: when `rx_s`=0, go to START with `cnt`=0.
- START: when `cnt` = CLOCKS_PER_BIT/2 - 1 (integer division), sample `rx_s`.
  - Sample 0: go to DATA with `cnt`=0 and index=0.
  - Sample 1: glitch. Return to IDLE; nothing is recorded.
- DATA: every time `cnt` = CLOCKS_PER_BIT-1, shift `rx_s` into the shift register, LSB first. After bit 7, go to STOP.
- STOP: when `cnt` = CLOCKS_PER_BIT-1, sample `rx_s`.
  - Sample 1: push the byte and go to IDLE.
  - Sample 0: set `framing_error`, discard the byte, and go to WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s`=1, then go to IDLE. This prevents a break condition from being read as a start bit.
- Push rule: the push is accepted if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the byte is dropped and `overrun_error` is set.
- Pop and push in the same cycle leave the count unchanged; the order of the stored data is preserved.
- `clear_errors` on the same cycle as a new error event: the set wins and the flag stays 1.
- The FIFO is a circular buffer. Read/write pointers wrap modulo FIFO_DEPTH, and the count is kept log2(FIFO_DEPTH)+1 bits wide.

## Timing
- Reset values:
  - Outputs: `rx_valid`=0, `rx_data`=8'h00, `rx_busy`=0, `framing_error`=0, `overrun_error`=0.
  - Internals: FSM=IDLE, FIFO empty, pointers=0.
- Reset in the middle of a frame abandons the partial byte. After reset the FSM needs a fresh falling edge on `rx_s`.
- Line-to-detect latency: 2 cycles through the synchronizer.
- Start sample: CLOCKS_PER_BIT/2 cycles after the falling edge is detected. Each data bit is sampled CLOCKS_PER_BIT cycles after the previous sample.
- Byte visibility: `rx_valid` rises on the cycle after the stop-bit sample, and `rx_data` is valid on that same cycle.
- Pop timing: after a pop, the next entry (or 8'h00 if the FIFO is now empty) appears on the following cycle.
- Error flags are set on the cycle after the offending sample. They clear on the cycle after `clear_errors`.
- `rx_busy` is high from the first cycle in START through the last cycle in STOP or WAIT_IDLE.

## Structure
- Add `serial_pkg` containing `rx_state_t` (enum of the 5 states) and `DEFAULT_CLOCKS_PER_BIT = 52`. `serial_transmitter` should import the same constant.
- Sub-module `serial_rx_fifo`: parameters WIDTH and DEPTH; ports push/pop, data in/out, full, empty.
- The top-level instance is wired to the MMIO decoder in `top` at 0x0003000C (status/data); that integration is out of scope here.

## Test plan
Benches use CLOCKS_PER_BIT=8 and FIFO_DEPTH=4.
- Frame 0xA5 with a good stop bit → `rx_valid`=1 with `rx_data`=8'hA5 one cycle after the stop sample; pop → `rx_valid`=0, `rx_data`=8'h00.
- 2-cycle low glitch on an idle line → FSM returns to IDLE, no push, no error flags.
- Frame 0x3C with the stop bit driven low, line held low for 20 cycles → `framing_error`=1, FIFO empty, no new frame until the line returns high; then `clear_errors` → flag=0.
- Send 5 bytes 0x01..0x05 with no pops → FIFO holds 0x01..0x04, `overrun_error`=1; popping returns exactly 0x01..0x04.
- FIFO full with a pop on the exact push cycle of 0x55 → no overrun, count stays 4, 0x55 is the last entry.
- `reset`=0 asserted mid-DATA of 0xFF → all outputs at reset values; a following 0x12 frame is received correctly.
